elastic_operator: RTL



---
 rtl/elastic_operator_if.sv | 34 +++
 rtl/elastic_operator.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/elastic_operator_if.sv
// Handshake bundle for elastic_operator: the upstream req/ack join channels
// and the downstream req/ack fork branches with the shared result token.
interface elastic_operator_if #(
    parameter int data_width  = 32,
    parameter int input_size  = 1,
    parameter int output_size = 1
);
    logic [input_size-1:0]            req_l;
    logic [input_size-1:0]            ack_l;
    logic [data_width*input_size-1:0] din;
    logic [output_size-1:0]           req_r;
    logic [output_size-1:0]           ack_r;
    logic [data_width-1:0]            dout;

    // Operator node side.
    modport slave (
        output req_l,
        input  ack_l,
        input  din,
        input  req_r,
        output ack_r,
        output dout
    );

    // Producer / consumer side.
    modport master (
        input  req_l,
        output ack_l,
        output din,
        output req_r,
        input  ack_r,
        input  dout
    );
endinterface

// File: rtl/elastic_operator.sv
// elastic_operator: joins input_size req/ack channels, applies one arithmetic
// op, buffers results in a depth-entry FIFO and forks every result to
// output_size consumer branches that are served independently.
// Optional feature: define ELASTIC_OPERATOR_STATS_EN to count cycles in which
// a complete operand set is held back only by a full FIFO (stall_count).
module elastic_operator #(
    parameter int    data_width  = 32,
    parameter string op          = "reg",
    parameter int    immediate   = 0,
    parameter int    input_size  = 1,
    parameter int    output_size = 1,
    parameter int    depth       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    elastic_operator_if.slave     bus,
    output logic [$clog2(depth):0] level,
    output logic [31:0]           count,
    output logic [31:0]           stall_count
);
    localparam int ptr_w = $clog2(depth);
    localparam int lvl_w = ptr_w + 1;

    typedef logic [ptr_w-1:0]      ptr_t;
    typedef logic [lvl_w-1:0]      lvl_t;
    typedef logic [data_width-1:0] word_t;
    typedef enum logic [1:0] {OP_PASS, OP_ADD, OP_SUB, OP_MUL} op_kind_e;

    // reg/in/out simply forward slice 0; the *i variants pair slice 0 with the immediate.
    localparam bit use_imm = (op == "addi") || (op == "subi") || (op == "muli");
    localparam op_kind_e kind = (op == "add" || op == "addi") ? OP_ADD :
                                (op == "sub" || op == "subi") ? OP_SUB :
                                (op == "mul" || op == "muli") ? OP_MUL : OP_PASS;
    localparam lvl_t  depth_lvl = lvl_t'(depth);
    localparam word_t imm       = word_t'(immediate);

    logic [input_size-1:0]  slot_full;
    word_t                  slot_data [input_size];
    word_t                  mem [depth];
    ptr_t                   wr_ptr;
    ptr_t                   rd_ptr;
    logic [output_size-1:0] served;
    logic [output_size-1:0] issue;
    word_t                  result;
    logic                   fire;
    logic                   pop;

    // A full operand set fires only if the FIFO has room; otherwise the slots hold (backpressure).
    assign fire = (&slot_full) && (level < depth_lvl);

    // The head leaves once every branch has either been served earlier or is acked now.
    assign pop = (level != '0) && (&(served | issue));

    // Apply the configured operation to the held operands (modulo 2^data_width).
    always_comb begin
        // NOTE: the default assignment up front covers every path, so no latch is inferred.
        result = slot_data[0];
        if (use_imm) begin
            case (kind)
                OP_ADD:  result = slot_data[0] + imm;
                OP_SUB:  result = slot_data[0] - imm;
                OP_MUL:  result = slot_data[0] * imm;
                default: result = slot_data[0];
            endcase
        end else begin
            for (int i = 1; i < input_size; i++) begin
                case (kind)
                    OP_ADD:  result = result + slot_data[i];
                    OP_SUB:  result = result - slot_data[i];
                    OP_MUL:  result = result * slot_data[i];
                    default: ;
                endcase
            end
        end
    end

    // A branch is acked when a token is waiting, it asks, has not taken this token, and was not acked last cycle.
    always_comb begin
        issue = '0;
        for (int j = 0; j < output_size; j++) begin
            issue[j] = (level != '0) && bus.req_r[j] && !served[j] && !bus.ack_r[j];
        end
    end

    // Input join: request while empty, capture on ack, release every slot on fire.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every reader sees the pre-edge value.
        if (rst) begin
            bus.req_l <= '0;
            slot_full <= '0;
        end else begin
            for (int i = 0; i < input_size; i++) begin
                if (fire) begin
                    slot_full[i] <= 1'b0;
                end else if (bus.req_l[i] && bus.ack_l[i]) begin
                    slot_data[i] <= bus.din[data_width*i +: data_width];
                    slot_full[i] <= 1'b1;
                    bus.req_l[i] <= 1'b0;
                end else if (!slot_full[i] && !bus.req_l[i]) begin
                    bus.req_l[i] <= 1'b1;
                end
            end
        end
    end

    // Result storage written at the tail on every fire.
    // NOTE: the array has no reset; level and the pointers decide which entries are live.
    always_ff @(posedge clk) begin
        if (fire) begin
            mem[wr_ptr] <= result;
        end
    end

    // Fork side, FIFO pointers, occupancy and the push counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ack_r <= '0;
            bus.dout  <= '0;
            served    <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            level     <= '0;
            count     <= '0;
        end else begin
            bus.ack_r <= issue;
            if (|issue) begin
                bus.dout <= mem[rd_ptr];
            end
            if (pop) begin
                served <= '0;
                rd_ptr <= rd_ptr + ptr_t'(1);
            end else begin
                served <= served | issue;
            end
            if (fire) begin
                wr_ptr <= wr_ptr + ptr_t'(1);
                count  <= count + 32'd1;
            end
            case ({fire, pop})
                2'b10:   level <= level + lvl_t'(1);
                2'b01:   level <= level - lvl_t'(1);
                default: level <= level;
            endcase
        end
    end

`ifdef ELASTIC_OPERATOR_STATS_EN
    // Count cycles where a complete operand set waits only because the FIFO is full.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if ((&slot_full) && (level == depth_lvl)) begin
            stall_count <= stall_count + 32'd1;
        end
    end
`else
    assign stall_count = '0;
`endif
endmodule
